fir_to_fft_stall_watchdog: RTL and testbench
============================================

# fir_to_fft_stall_watchdog

Stall watchdog and recovery sequencer for the FIR-to-FFT HLS core. It consumes the per-channel AXIS blocking indicators and the core idle flag, and times how long each channel stays blocked. When a channel stays blocked past a programmable limit, it runs a fixed recovery sequence: drain, then core reset, then holdoff. It sits beside the core's deadlock monitor and drives the core's reset and the downstream drain (force-ready) control.

## Interface
Parameters:
- NUM_CH, 2, number of AXIS channels monitored
- CNT_W, 16, stall counter width
- DRAIN_CYCLES, 32, maximum cycles in DRAIN
- RST_CYCLES, 16, width of core_reset pulse in cycles
- HOLDOFF_CYCLES, 64, quiet period after recovery before monitoring resumes

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- axis_block_sigs  in  NUM_CH  per-channel AXIS blocked indicator from core
- inst_idle  in  1  core idle flag
- enable  in  1  arm watchdog
- stall_limit  in  CNT_W  trip threshold in cycles; 0 = watchdog disabled
- clear  in  1  clears blocked_ch and trip_count
- core_reset  out  1  active-high reset to FIR-to-FFT core
- drain  out  1  force downstream tready / discard
- blocked_ch  out  NUM_CH  sticky mask of channels that caused the last trip
- trip_count  out  8  saturating count of trips
- state  out  2  current FSM state: MONITOR=0, DRAIN=1, RESET=2, HOLDOFF=3

## Operation
- Reset:
  - state=MONITOR.
  - All counters = 0.
  - core_reset=0, drain=0, blocked_ch=0, trip_count=0.
- Per-channel stall counter:
  - Increments each cycle its block sig is 1.
  - Clears to 0 on the first cycle the sig is 0.
  - Saturates at 2^CNT_W-1.
  - Held at 0 when state≠MONITOR or enable=0 or stall_limit=0.
- MONITOR:
  - Trip when enable=1, stall_limit≠0, and any counter ≥ stall_limit.
  - On trip:
    - blocked_ch ← mask of channels with counter ≥ stall_limit (replaces the previous value).
    - trip_count ← trip_count+1, saturating at 255.
    - Next state is DRAIN.
- DRAIN:
  - drain=1; an internal cycle counter runs.
  - If all block sigs = 0 and inst_idle=1: go to HOLDOFF (soft recovery, no reset).
  - Otherwise, after DRAIN_CYCLES cycles in DRAIN: go to RESET.
- RESET:
  - core_reset=1 and drain=1 for exactly RST_CYCLES cycles.
  - Then go to HOLDOFF.
- HOLDOFF:
  - All outputs are low except the status outputs.
  - Stays HOLDOFF_CYCLES cycles, then returns to MONITOR with counters 0.
- enable=0 outside MONITOR does not abort a sequence; the sequence completes.
- clear:
  - Zeroes blocked_ch and trip_count in any state.
  - On the same cycle as a trip, the trip wins: blocked_ch = new mask, trip_count=1.
  - clear never alters the FSM or counters.
- stall_limit is sampled continuously.
  - Lowering it below a live count trips on the next evaluation.

## Timing
- All outputs are registered.
- With block sig high from cycle 0 and limit L:
  - The counter reads k at cycle k.
  - state=DRAIN, drain=1, and blocked_ch/trip_count are updated at cycle L+1.
- DRAIN with no soft recovery:
  - Lasts exactly DRAIN_CYCLES cycles.
  - core_reset rises on the following cycle and is high exactly RST_CYCLES cycles.
- Soft-recovery condition is sampled each DRAIN cycle; HOLDOFF is entered on the next edge.
- Holdoff is exactly HOLDOFF_CYCLES cycles. The earliest possible re-trip is L+1 cycles after re-entering MONITOR.
- Reset mid-sequence: within one cycle, core_reset=0, drain=0, state=MONITOR, and status is zeroed.

## Structure
- Package fir_to_fft_wd_pkg:
  - state enum with encodings 0–3
  - trip_count width constant (8)
- Sub-module fir_to_fft_stall_counter:
  - one per channel, generated NUM_CH times
  - inputs: blk, hold; output: count
  - implements the saturating/clear rules
- Top level contains the FSM, the shared phase counter (sized for max(DRAIN_CYCLES, RST_CYCLES, HOLDOFF_CYCLES)), and the status registers.

## Test plan
- Basic trip:
  - Stimulus: L=10, ch0 blocked continuously, inst_idle=0.
  - Required: state=DRAIN at cycle 11; RESET at 43; core_reset high cycles 43–58; HOLDOFF 59–122; MONITOR at 123; blocked_ch=01; trip_count=1.
- Soft recovery and no-trip pulses:
  - Stimulus: L=10, ch1 blocked 12 cycles, then block low and inst_idle=1.
  - Required: DRAIN then HOLDOFF with core_reset never asserted; blocked_ch=10.
  - Stimulus: ch0 blocked 9 cycles, low 1, blocked 9 again.
  - Required: no trip.
- Simultaneous channels plus clear:
  - Stimulus: both channels blocked together; assert clear on the trip cycle.
  - Required: blocked_ch=11, trip_count=1; a later clear zeroes both.
- Disable paths:
  - Stimulus: stall_limit=0, or enable=0, with 1000 blocked cycles.
  - Required: no trip, counters stay 0.
  - Stimulus: enable dropped during RESET.
  - Required: full RST_CYCLES pulse still produced.
- Saturation and reset:
  - Stimulus: 260 forced trips.
  - Required: trip_count=255.
  - Stimulus: reset asserted mid-RESET.
  - Required: core_reset=0 and state=MONITOR next cycle.

Source files
------------

// File: rtl/fir_to_fft_wd_pkg.sv
// Shared types and constants for the FIR-to-FFT stall watchdog.
// Latency: n/a (types only).
// Backpressure: n/a.
package fir_to_fft_wd_pkg;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_RESET   = 2'd2,
    ST_HOLDOFF = 2'd3
  } wd_state_t;

  localparam int TRIP_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fir_to_fft_stall_counter.sv
// Per-channel stall timer: counts consecutive blocked cycles, saturating.
// Latency: count reflects blk one cycle later (registered).
// Backpressure: none; hold forces the count to zero.
// Ports: clock, reset (sync, active-high), blk (channel blocked),
//        hold (force zero), count (consecutive blocked cycles).
module fir_to_fft_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             blk,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || hold || !blk) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fir_to_fft_stall_watchdog.sv
// Stall watchdog and drain/reset/holdoff recovery sequencer for the FIR-to-FFT core.
// Latency: all outputs registered; a trip shows one cycle after a count reaches stall_limit.
// Backpressure: none; drain forces downstream ready while recovering.
// Ports: clock, reset (sync, active-high); axis_block_sigs, inst_idle from the core;
//        enable, stall_limit, clear (control); core_reset, drain (recovery outputs);
//        blocked_ch, trip_count, state (status).
module fir_to_fft_stall_watchdog
  import fir_to_fft_wd_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 16,
  parameter int DRAIN_CYCLES   = 32,
  parameter int RST_CYCLES     = 16,
  parameter int HOLDOFF_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     axis_block_sigs,
  input  logic                  inst_idle,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      stall_limit,
  input  logic                  clear,
  output logic                  core_reset,
  output logic                  drain,
  output logic [NUM_CH-1:0]     blocked_ch,
  output logic [TRIP_CNT_W-1:0] trip_count,
  output logic [1:0]            state
);

  localparam int PH_MAX = max3(DRAIN_CYCLES, RST_CYCLES, HOLDOFF_CYCLES);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  wd_state_t         state_q, state_d;
  logic [PH_W-1:0]   phase_q;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] over_mask;
  logic              armed, trip, hold, soft_ok;

  assign armed   = enable && (stall_limit != '0);
  assign trip    = (state_q == ST_MONITOR) && armed && (|over_mask);
  // Trip is included so the counters are already zero on the first DRAIN cycle.
  assign hold    = (state_q != ST_MONITOR) || !armed || trip;
  assign soft_ok = (axis_block_sigs == '0) && inst_idle;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fir_to_fft_stall_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .blk   (axis_block_sigs[g]),
      .hold  (hold),
      .count (cnt[g])
    );
  end

  always_comb begin
    over_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      over_mask[i] = (cnt[i] >= stall_limit);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MONITOR: if (trip) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // Soft recovery takes priority over the drain timeout.
        if (soft_ok)                                  state_d = ST_HOLDOFF;
        else if (phase_q == PH_W'(DRAIN_CYCLES - 1))  state_d = ST_RESET;
      end
      ST_RESET:   if (phase_q == PH_W'(RST_CYCLES - 1))     state_d = ST_HOLDOFF;
      ST_HOLDOFF: if (phase_q == PH_W'(HOLDOFF_CYCLES - 1)) state_d = ST_MONITOR;
      default:    state_d = ST_MONITOR;
    endcase
  end

  // Phase counter restarts on every state change, so it counts cycles spent in the current state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_MONITOR;
      phase_q    <= '0;
      core_reset <= 1'b0;
      drain      <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || (state_q == ST_MONITOR)) begin
        phase_q <= '0;
      end else begin
        phase_q <= phase_q + 1'b1;
      end
      // Outputs decoded from the next state so they align with the registered state.
      core_reset <= (state_d == ST_RESET);
      drain      <= (state_d == ST_DRAIN) || (state_d == ST_RESET);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      blocked_ch <= '0;
      trip_count <= '0;
    end else if (trip) begin
      blocked_ch <= over_mask;
      if (clear) begin
        trip_count <= TRIP_CNT_W'(1);
      end else if (trip_count != '1) begin
        trip_count <= trip_count + 1'b1;
      end
    end else if (clear) begin
      blocked_ch <= '0;
      trip_count <= '0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_fir_to_fft_stall_watchdog.sv
module tb_fir_to_fft_stall_watchdog;
  import fir_to_fft_wd_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  axis_block_sigs;
  logic        inst_idle;
  logic        enable;
  logic [15:0] stall_limit;
  logic        clear;
  logic        core_reset;
  logic        drain;
  logic [1:0]  blocked_ch;
  logic [7:0]  trip_count;
  logic [1:0]  state;

  fir_to_fft_stall_watchdog #(
    .NUM_CH(2), .CNT_W(16), .DRAIN_CYCLES(32), .RST_CYCLES(16), .HOLDOFF_CYCLES(64)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle       (inst_idle),
    .enable          (enable),
    .stall_limit     (stall_limit),
    .clear           (clear),
    .core_reset      (core_reset),
    .drain           (drain),
    .blocked_ch      (blocked_ch),
    .trip_count      (trip_count),
    .state           (state)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // One record: inputs applied at cycle cyc, and the outputs expected in that cycle.
  typedef struct {
    int         cyc;
    logic       en;
    logic [1:0] blk;
    logic       idle;
    logic       clr;
    logic [1:0] st;
    logic       cr;
    logic       dr;
    logic [1:0] bch;
    logic [7:0] tc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input int c, input logic e, input logic [1:0] b, input logic i,
                             input logic cl, input logic [1:0] s, input logic r, input logic d,
                             input logic [1:0] bc, input logic [7:0] t);
    vec_t x;
    x.cyc = c; x.en = e; x.blk = b; x.idle = i; x.clr = cl;
    x.st = s; x.cr = r; x.dr = d; x.bch = bc; x.tc = t;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    axis_block_sigs = 2'b00;
    inst_idle = 1'b0;
    enable = 1'b1;
    stall_limit = 16'd10;
    clear = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic run_table(input string nm, input int ncyc, output int cr_cnt, output int dr_cnt);
    cr_cnt = 0;
    dr_cnt = 0;
    for (int c = 0; c <= ncyc; c++) begin
      foreach (tbl[i]) begin
        if (tbl[i].cyc == c) begin
          enable          = tbl[i].en;
          axis_block_sigs = tbl[i].blk;
          inst_idle       = tbl[i].idle;
          clear           = tbl[i].clr;
          #1;
          chk($sformatf("%s c%0d state", nm, c), 32'(state), 32'(tbl[i].st));
          chk($sformatf("%s c%0d core_reset", nm, c), 32'(core_reset), 32'(tbl[i].cr));
          chk($sformatf("%s c%0d drain", nm, c), 32'(drain), 32'(tbl[i].dr));
          chk($sformatf("%s c%0d blocked_ch", nm, c), 32'(blocked_ch), 32'(tbl[i].bch));
          chk($sformatf("%s c%0d trip_count", nm, c), 32'(trip_count), 32'(tbl[i].tc));
        end
      end
      if (core_reset === 1'b1) cr_cnt++;
      if (drain === 1'b1) dr_cnt++;
      if (c < ncyc) step();
    end
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (state == tgt) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cr, dr, bad;
    bit ok;

    // Basic trip, full drain/reset/holdoff, and earliest re-trip.
    do_reset();
    tbl.delete();
    tbl.push_back(v(  0, 1, 2'b01, 0, 0, ST_MONITOR, 0, 0, 2'b00, 0));
    tbl.push_back(v( 10, 1, 2'b01, 0, 0, ST_MONITOR, 0, 0, 2'b00, 0));
    tbl.push_back(v( 11, 1, 2'b01, 0, 0, ST_DRAIN,   0, 1, 2'b01, 1));
    tbl.push_back(v( 42, 1, 2'b01, 0, 0, ST_DRAIN,   0, 1, 2'b01, 1));
    tbl.push_back(v( 43, 1, 2'b01, 0, 0, ST_RESET,   1, 1, 2'b01, 1));
    tbl.push_back(v( 58, 1, 2'b01, 0, 0, ST_RESET,   1, 1, 2'b01, 1));
    tbl.push_back(v( 59, 1, 2'b01, 0, 0, ST_HOLDOFF, 0, 0, 2'b01, 1));
    tbl.push_back(v(122, 1, 2'b01, 0, 0, ST_HOLDOFF, 0, 0, 2'b01, 1));
    tbl.push_back(v(123, 1, 2'b01, 0, 0, ST_MONITOR, 0, 0, 2'b01, 1));
    tbl.push_back(v(133, 1, 2'b01, 0, 0, ST_MONITOR, 0, 0, 2'b01, 1));
    tbl.push_back(v(134, 1, 2'b01, 0, 0, ST_DRAIN,   0, 1, 2'b01, 2));
    run_table("basic", 134, cr, dr);
    chk("basic core_reset cycles", cr, 16);
    chk("basic drain cycles", dr, 49);

    // Soft recovery: ch1 blocked 12 cycles, then idle.
    do_reset();
    tbl.delete();
    tbl.push_back(v( 0, 1, 2'b10, 0, 0, ST_MONITOR, 0, 0, 2'b00, 0));
    tbl.push_back(v(11, 1, 2'b10, 0, 0, ST_DRAIN,   0, 1, 2'b10, 1));
    tbl.push_back(v(12, 1, 2'b00, 1, 0, ST_DRAIN,   0, 1, 2'b10, 1));
    tbl.push_back(v(13, 1, 2'b00, 1, 0, ST_HOLDOFF, 0, 0, 2'b10, 1));
    tbl.push_back(v(76, 1, 2'b00, 1, 0, ST_HOLDOFF, 0, 0, 2'b10, 1));
    tbl.push_back(v(77, 1, 2'b00, 1, 0, ST_MONITOR, 0, 0, 2'b10, 1));
    run_table("soft", 77, cr, dr);
    chk("soft core_reset cycles", cr, 0);
    chk("soft drain cycles", dr, 2);

    // Both channels together with clear on the trip cycle (trip_count was 1).
    tbl.delete();
    tbl.push_back(v( 0, 1, 2'b11, 0, 0, ST_MONITOR, 0, 0, 2'b10, 1));
    tbl.push_back(v(10, 1, 2'b11, 0, 1, ST_MONITOR, 0, 0, 2'b10, 1));
    tbl.push_back(v(11, 1, 2'b11, 0, 0, ST_DRAIN,   0, 1, 2'b11, 1));
    tbl.push_back(v(12, 1, 2'b11, 0, 1, ST_DRAIN,   0, 1, 2'b11, 1));
    tbl.push_back(v(13, 1, 2'b11, 0, 0, ST_DRAIN,   0, 1, 2'b00, 0));
    run_table("clear", 13, cr, dr);

    // Short pulses that never reach the limit.
    do_reset();
    tbl.delete();
    tbl.push_back(v( 0, 1, 2'b01, 0, 0, ST_MONITOR, 0, 0, 2'b00, 0));
    tbl.push_back(v( 9, 1, 2'b00, 0, 0, ST_MONITOR, 0, 0, 2'b00, 0));
    tbl.push_back(v(10, 1, 2'b01, 0, 0, ST_MONITOR, 0, 0, 2'b00, 0));
    tbl.push_back(v(19, 1, 2'b00, 0, 0, ST_MONITOR, 0, 0, 2'b00, 0));
    tbl.push_back(v(25, 1, 2'b00, 0, 0, ST_MONITOR, 0, 0, 2'b00, 0));
    run_table("pulses", 25, cr, dr);
    chk("pulses drain cycles", dr, 0);

    // Disable paths: limit 0, then enable 0, each with 1000 blocked cycles.
    do_reset();
    stall_limit = 16'd0;
    axis_block_sigs = 2'b11;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (state != ST_MONITOR || drain !== 1'b0) bad++;
      step();
    end
    chk("limit0 non-monitor cycles", bad, 0);
    stall_limit = 16'd10;
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (state != ST_MONITOR || drain !== 1'b0) bad++;
      step();
    end
    chk("disabled non-monitor cycles", bad, 0);
    // Counters must have been held at zero, so arming takes a full L+1 cycles;
    // enable is then dropped mid-RESET and the pulse must still be complete.
    tbl.delete();
    tbl.push_back(v( 0, 1, 2'b11, 0, 0, ST_MONITOR, 0, 0, 2'b00, 0));
    tbl.push_back(v(10, 1, 2'b11, 0, 0, ST_MONITOR, 0, 0, 2'b00, 0));
    tbl.push_back(v(11, 1, 2'b11, 0, 0, ST_DRAIN,   0, 1, 2'b11, 1));
    tbl.push_back(v(45, 0, 2'b11, 0, 0, ST_RESET,   1, 1, 2'b11, 1));
    tbl.push_back(v(58, 0, 2'b11, 0, 0, ST_RESET,   1, 1, 2'b11, 1));
    tbl.push_back(v(59, 0, 2'b11, 0, 0, ST_HOLDOFF, 0, 0, 2'b11, 1));
    run_table("endrop", 59, cr, dr);
    chk("endrop core_reset cycles", cr, 16);
    chk("endrop drain cycles", dr, 48);

    // Trip counter saturation over 260 soft-recovered trips.
    do_reset();
    stall_limit = 16'd1;
    inst_idle = 1'b1;
    for (int t = 1; t <= 260; t++) begin
      axis_block_sigs = 2'b01;
      wait_state(ST_DRAIN, 10, ok);
      if (!ok) begin
        chk($sformatf("sat trip %0d reached DRAIN", t), 0, 1);
        break;
      end
      axis_block_sigs = 2'b00;
      wait_state(ST_MONITOR, 100, ok);
      if (!ok) begin
        chk($sformatf("sat trip %0d back to MONITOR", t), 0, 1);
        break;
      end
      if (t == 1)   chk("sat trip_count after 1", 32'(trip_count), 1);
      if (t == 255) chk("sat trip_count after 255", 32'(trip_count), 255);
    end
    chk("sat trip_count after 260", 32'(trip_count), 255);

    // Reset asserted in the middle of RESET.
    do_reset();
    axis_block_sigs = 2'b01;
    wait_state(ST_RESET, 100, ok);
    chk("midrst reached RESET", 32'(ok), 1);
    step();
    step();
    chk("midrst core_reset before", 32'(core_reset), 1);
    chk("midrst trip_count before", 32'(trip_count), 1);
    reset = 1'b1;
    step();
    chk("midrst state", 32'(state), 32'(ST_MONITOR));
    chk("midrst core_reset", 32'(core_reset), 0);
    chk("midrst drain", 32'(drain), 0);
    chk("midrst blocked_ch", 32'(blocked_ch), 0);
    chk("midrst trip_count", 32'(trip_count), 0);
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
